// File: rtl/pll_lock_detect.sv
// pll_lock_detect: windowed fb_clk edge counter with lock qualification; `define PLL_LOCK_LOSS_FLAG_EN for sticky lock_lost
module pll_lock_detect #(
    parameter int WINDOW       = 64,
    parameter int EXP_COUNT    = 8,
    parameter int TOL          = 1,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        enable,
    input  logic        fb_clk,
    input  logic        clear_lost,
    output logic        locked,
    output logic [15:0] fb_count,
    output logic        meas_valid,
    output logic        lock_lost
);
    localparam logic [1:0] IDLE = 2'd0, MEASURE = 2'd1, EVAL = 2'd2;
    localparam logic signed [16:0] EXP_S = 17'(EXP_COUNT), TOL_S = 17'(TOL);
    localparam logic [3:0] GOOD_MAX = 4'(LOCK_WINDOWS);
    logic [1:0] state;
    logic [2:0] sync;
    logic [15:0] win_cnt, edge_cnt, edge_inc;
    logic [3:0] good;
    logic det, last, match, drop;
    logic signed [16:0] diff;
    always_comb begin
        det = sync[1] & ~sync[2];
        last = win_cnt == 16'(WINDOW - 1);
        edge_inc = edge_cnt + {15'd0, det && edge_cnt != 16'hFFFF};
        diff = $signed({1'b0, edge_cnt}) - EXP_S;
        match = diff <= TOL_S && diff >= -TOL_S;
    end
    assign meas_valid = state == EVAL;
    always_ff @(posedge clk_in) begin
        if (rst) sync <= '0;
        else sync <= {sync[1:0], fb_clk};
    end
    // fb_count is loaded on entry to EVAL so it is already valid while meas_valid is high
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            good     <= '0;
            locked   <= 1'b0;
            fb_count <= '0;
            drop     <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            good   <= '0;
            locked <= 1'b0;
            drop   <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= MEASURE;
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                end
                MEASURE: begin
                    win_cnt  <= win_cnt + 16'd1;
                    edge_cnt <= edge_inc;
                    if (last) begin
                        state    <= EVAL;
                        fb_count <= edge_inc;
                    end
                end
                EVAL: begin
                    state    <= MEASURE;
                    win_cnt  <= '0;
                    edge_cnt <= {15'd0, det};
                    good     <= match ? (good == GOOD_MAX ? good : good + 4'd1) : 4'd0;
                    locked   <= match && good >= GOOD_MAX - 4'd1;
                    drop     <= locked && !match;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PLL_LOCK_LOSS_FLAG_EN
    always_ff @(posedge clk_in) begin
        if (rst) lock_lost <= 1'b0;
        else lock_lost <= drop | (lock_lost & ~clear_lost);
    end
`else
    logic unused_lost;
    assign unused_lost = clear_lost ^ drop;
    assign lock_lost = 1'b0;
`endif
endmodule

// File: doc/pll_lock_detect.md
PLL_LOCK_DETECT -- requirements
Module: pll_lock_detect

Interface
REQ-001 Parameter WINDOW, default 64: clk_in cycles per measurement window; legal range 2..65535.
REQ-002 Parameter EXP_COUNT, default 8: expected fb_clk rising edges per window.
REQ-003 Parameter TOL, default 1: allowed absolute deviation from EXP_COUNT.
REQ-004 Parameter LOCK_WINDOWS, default 4: consecutive in-tolerance windows required for lock; legal range 1..15.
REQ-005 clk_in  input  1  reference clock; the only clock.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 enable  input  1  run measurement when high.
REQ-008 fb_clk  input  1  divided PLL feedback; asynchronous; frequency at most clk_in/4.
REQ-009 clear_lost  input  1  clears lock_lost.
REQ-010 locked  output  1  lock indication.
REQ-011 fb_count  output  16  edge count of the last completed window.
REQ-012 meas_valid  output  1  one-cycle pulse when fb_count updates.
REQ-013 lock_lost  output  1  sticky loss-of-lock flag.

Function
REQ-014 fb_clk SHALL pass through a 2-flop synchronizer; a rising edge is detected from sync stage 2 vs a third flop, giving 3-cycle detect latency.
REQ-015 The synchronizer SHALL run regardless of enable or FSM state.
REQ-016 The FSM SHALL have states IDLE, MEASURE and EVAL.
REQ-017 IDLE -> MEASURE when enable=1; window counter cleared; edge counter cleared.
REQ-018 In MEASURE the window counter SHALL increment every cycle, and each detected edge SHALL increment the 16-bit edge counter, saturating at 16'hFFFF.
REQ-019 MEASURE -> EVAL when the window counter equals WINDOW-1; an edge detected in that cycle SHALL be counted.
REQ-020 EVAL SHALL last 1 cycle, then go to MEASURE; fb_count <= edge counter, meas_valid=1 for that cycle.
REQ-021 An edge detected during EVAL SHALL load the next window's edge counter with 1 (otherwise 0); no edge is lost.
REQ-022 Match: |edge_cnt - EXP_COUNT| <= TOL, computed in 17-bit signed arithmetic.
REQ-023 In EVAL on a match, the good counter SHALL increment, saturating at LOCK_WINDOWS; locked=1 from the cycle after the good counter reaches LOCK_WINDOWS.
REQ-024 In EVAL on a mismatch, the good counter SHALL clear and locked SHALL be 0 from the next cycle.
REQ-025 enable=0 in any state SHALL give the following next cycle: state IDLE, locked=0, good counter=0, no meas_valid; fb_count retains its value.
REQ-026 Re-enable SHALL always start a fresh full window; no partial window is evaluated.

Reset
REQ-027 rst=1 SHALL force state IDLE, locked=0, fb_count=0, meas_valid=0, lock_lost=0, and all counters and synchronizer flops to 0 at the next clk_in edge.
REQ-028 rst SHALL take priority over enable and clear_lost.
REQ-029 rst mid-window SHALL discard the partial window with no meas_valid.

Configuration
REQ-030 Macro PLL_LOCK_LOSS_FLAG_EN defined: lock_lost SHALL set on the cycle after locked falls 1->0 due to a mismatch; it is not set when locked falls due to enable or rst.
REQ-031 With PLL_LOCK_LOSS_FLAG_EN defined, lock_lost SHALL clear when clear_lost=1, and set SHALL win over simultaneous clear.
REQ-032 Macro PLL_LOCK_LOSS_FLAG_EN undefined: lock_lost SHALL be constant 0 and clear_lost SHALL be ignored.

Verification (defaults: WINDOW=64, EXP_COUNT=8, TOL=1, LOCK_WINDOWS=4)
REQ-033 rst 2 cycles, enable=1, fb_clk period 8 clk_in -> meas_valid every 65 cycles; fb_count in {8,9}; locked=1 the cycle after the 4th meas_valid.
REQ-034 After lock, fb_clk period changes to 5 -> first evaluation with fb_count>=12 drops locked the next cycle; lock_lost=1 with the macro and 0 without it.
REQ-035 enable=0 at cycle 30 of a window while locked -> locked=0 next cycle, no meas_valid, lock_lost stays 0; re-enable gives the next meas_valid 65 cycles later.
REQ-036 fb_clk held 0 -> fb_count=0 every window; locked never asserts.
REQ-037 rst=1 mid-window while locked -> all outputs 0 next cycle; after rst=0 with enable=1, lock re-acquires after 4 windows.
REQ-038 With the macro defined, clear_lost=1 in the same cycle lock_lost sets -> lock_lost=1; clear_lost one cycle later -> lock_lost=0.
